clkdiv_meter: RTL and testbench
===============================

# clkdiv_meter

Clock-ratio measurement block for the receiving end of our fractional clock dividers. It samples a divided clock (`clk_in`) in the `sys_clk` domain and counts `sys_clk` cycles over 2^AVG_LOG2 consecutive `clk_in` periods, so fractional ratios such as 5.5 resolve to an integer sum (11 over 2 periods). It compares each result against an expected count and maintains a lock flag. It sits beside any divider output in the clock-generation area as a built-in checker and frequency monitor.

## Interface
- `CNT_W`, 16: width of the period/high-time accumulators.
- `AVG_LOG2`, 1: log2 of the number of `clk_in` periods accumulated per measurement (0..4).
- `EXPECT`, 11: expected `period_sum` value.
- `TOL`, 1: allowed absolute deviation from `EXPECT` for a match.
- `TIMEOUT`, 1024: maximum `sys_clk` cycles between `clk_in` rising edges.

Ports:
- `sys_clk` input 1: system clock; all logic is on its rising edge.
- `sys_rst` input 1: reset, asynchronous, active-high.
- `clk_in` input 1: clock under measurement; asynchronous, frequency ≤ `sys_clk`/4.
- `start` input 1: one-cycle pulse that begins measuring.
- `cont` input 1: 1 = re-arm automatically after each measurement.
- `period_sum` output CNT_W: `sys_clk` cycles spanning 2^AVG_LOG2 `clk_in` periods.
- `high_sum` output CNT_W: cycles with synchronized `clk_in` high over the same span.
- `meas_valid` output 1: one-cycle pulse; the sums are updated on this cycle.
- `locked` output 1: two consecutive matching measurements.
- `timeout` output 1: sticky; no edge was seen within `TIMEOUT` cycles.
- `busy` output 1: high when the FSM is not in IDLE.

## Operation
- `clk_in` passes through a 2-flop synchronizer plus a history flop. A rising edge `rise` is detected as sync=1 and history=0.
- FSM states: IDLE, ARM, MEAS, DONE.
  - IDLE → ARM on `start`. Entering ARM clears `timeout`.
  - ARM: wait for `rise`, then go to MEAS with `pcnt`=1, `hcnt`=1 and the edge counter at 0.
  - MEAS: `pcnt` increments every cycle. `hcnt` increments while sync=1. On each `rise` the edge counter increments. When it reaches 2^AVG_LOG2, go to DONE.
  - The terminating `rise` cycle is not counted. It starts the next span when `cont`=1.
  - DONE (1 cycle): latch `pcnt`→`period_sum` and `hcnt`→`high_sum`, pulse `meas_valid`, evaluate the match.
  - From DONE, go to MEAS if `cont`=1. The counters restart at 1, measuring back-to-back with no edge lost. Otherwise go to IDLE.
- Match is |`period_sum` − `EXPECT`| ≤ `TOL`, computed unsigned at CNT_W+1 bits.
  - `locked` sets when two consecutive DONEs both match.
  - `locked` clears on any mismatching DONE, on timeout, or on `start` from IDLE.
- Watchdog counter: resets on `rise` and on entering ARM. When it reaches `TIMEOUT` in ARM or MEAS:
  - set `timeout` and clear `locked`;
  - go to IDLE with no `meas_valid`;
  - leave `period_sum`/`high_sum` unchanged.
- `pcnt` and `hcnt` saturate at all-ones and never wrap.
- `start` outside IDLE is ignored. Dropping `cont` during MEAS finishes the current measurement, then goes to IDLE.

## Timing
- Reset values:
  - `period_sum`=0, `high_sum`=0
  - `meas_valid`=0, `locked`=0, `timeout`=0, `busy`=0
  - FSM in IDLE, synchronizer flops at 0.
- `rise` is detected 2–3 `sys_clk` cycles after the true `clk_in` edge. This latency is constant, so it cancels out of the sums.
- `meas_valid` asserts 1 cycle after the `rise` that terminates the measurement. The outputs are registered.
- `busy` rises the cycle after `start`.
- `timeout` rises the cycle after the watchdog reaches `TIMEOUT`.
- `sys_rst` mid-measurement returns everything to reset values immediately, with no `meas_valid`.

## Configuration
- `CLKDIV_METER_DUTY_EN` defined: the `hcnt` accumulator is built and `high_sum` reports the high time.
- Not defined: no `hcnt` logic is built and `high_sum` is tied to 0. All other behaviour is identical.

## Test plan
- Ideal divide-by-6 `clk_in` (50% duty), defaults, `start`, `cont`=0 → one `meas_valid` with `period_sum`=12 and `high_sum`=6. `locked`=0, then `busy`=0.
- Divide-by-5.5 model clock, `cont`=1 → every `meas_valid` shows `period_sum`=11. `locked`=1 after the 2nd pulse and stays 1.
- Divide-by-5.5 model, switched to divide-by-7 mid-run → the first DONE fully on the new clock gives `period_sum`=14. `locked` drops on that cycle.
- `clk_in` held low, `TIMEOUT`=64, `start` → `timeout`=1 after 64 cycles in ARM. `busy`=0, no `meas_valid`, sums unchanged.
- `sys_rst` pulsed during MEAS → all outputs at reset values. A later `start` measures normally (`period_sum`=12 for divide-by-6).
- `CNT_W`=4, divide-by-20 clock → `period_sum`=15 (saturated), mismatch, `locked`=0.

Source files
------------

// File: rtl/clkdiv_meter_if.sv
// clkdiv_meter_if: control and result signals of the clock-ratio meter.
//
// Handshake: meas_valid is a one-cycle valid strobe with no ready; the sums,
// locked and timeout are registered and stay stable between strobes, so a
// consumer that misses a strobe can still read the last result. start is a
// single-cycle request honoured only while busy is low.
interface clkdiv_meter_if #(
  parameter int CNT_W = 16
) ();
  logic             clk_in;
  logic             start;
  logic             cont;
  logic [CNT_W-1:0] period_sum;
  logic [CNT_W-1:0] high_sum;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output clk_in, start, cont,
    input  period_sum, high_sum, meas_valid, locked, timeout, busy, dbg_state
  );

  modport slave (
    input  clk_in, start, cont,
    output period_sum, high_sum, meas_valid, locked, timeout, busy, dbg_state
  );
endinterface

// File: rtl/clkdiv_meter.sv
// clkdiv_meter: counts sys_clk cycles over 2^AVG_LOG2 periods of an
// asynchronous divided clock, compares the sum to EXPECT +/- TOL and keeps a
// lock flag. A watchdog aborts the measurement when clk_in stops toggling.
// Optional feature macro: CLKDIV_METER_DUTY_EN builds the high-time
// accumulator; without it high_sum is tied to zero.
module clkdiv_meter #(
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 1,
  parameter int EXPECT   = 11,
  parameter int TOL      = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  clkdiv_meter_if.slave mif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int               N_EDGES   = 1 << AVG_LOG2;
  localparam int               EW        = AVG_LOG2 + 1;
  localparam logic [EW-1:0]    ECNT_LAST = EW'(N_EDGES - 1);
  localparam int               WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   EXP_V     = (CNT_W + 1)'(EXPECT);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic             rise, last_rise, wd_hit;
  logic             busy, arm_enter, done_enter, span_start, counting;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [EW-1:0]    ecnt_q, ecnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [CNT_W:0]   p_ext, diff;
  logic             match;
  logic [CNT_W-1:0] period_sum_q;
  logic             meas_valid_q, locked_q, prev_match_q, timeout_q;

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= mif.clk_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Edge, terminating-edge and watchdog decodes; a rise beats the watchdog
  always_comb begin
    rise      = sync2_q & ~hist_q;
    last_rise = rise && (ecnt_q == ECNT_LAST);
    wd_hit    = ((state_q == ARM) || (state_q == MEAS)) && !rise &&
                (wdog_q == WD_LAST);
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mif.start) state_d = ARM;
      ARM:     if (wd_hit) state_d = IDLE;
               else if (rise) state_d = MEAS;
      MEAS:    if (wd_hit) state_d = IDLE;
               else if (last_rise) state_d = DONE;
      DONE:    state_d = mif.cont ? MEAS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decodes driving the datapath
  always_comb begin
    busy       = (state_q != IDLE);
    arm_enter  = (state_q == IDLE) && mif.start;
    done_enter = (state_q == MEAS) && last_rise;
    // The first rise in ARM and every terminating rise open a new span,
    // so back-to-back measurements lose no edge.
    span_start = ((state_q == ARM) && rise) || done_enter;
    counting   = (state_q == MEAS) || (state_q == DONE);
  end

  // Next values of the period, edge and watchdog counters
  always_comb begin
    pcnt_d = pcnt_q;
    ecnt_d = ecnt_q;
    wdog_d = wdog_q;
    if (span_start) begin
      pcnt_d = CNT_W'(1);
      ecnt_d = '0;
    end else if (counting) begin
      pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
      if (rise) ecnt_d = ecnt_q + 1'b1;
    end
    if (arm_enter || rise) wdog_d = '0;
    else if (busy)         wdog_d = wdog_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pcnt_q <= '0;
      ecnt_q <= '0;
      wdog_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      ecnt_q <= ecnt_d;
      wdog_q <= wdog_d;
    end
  end

  // Match window on the sum about to be latched, unsigned at CNT_W+1 bits
  always_comb begin
    p_ext = {1'b0, pcnt_q};
    diff  = (p_ext >= EXP_V) ? (p_ext - EXP_V) : (EXP_V - p_ext);
    match = (diff <= TOL_V);
  end

  // Result latch, valid strobe, lock tracking and sticky timeout
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      period_sum_q <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      prev_match_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= done_enter;
      if (done_enter) begin
        period_sum_q <= pcnt_q;
        prev_match_q <= match;
        locked_q     <= match && prev_match_q;
      end
      if (arm_enter) begin
        timeout_q    <= 1'b0;
        locked_q     <= 1'b0;
        prev_match_q <= 1'b0;
      end
      if (wd_hit) begin
        timeout_q    <= 1'b1;
        locked_q     <= 1'b0;
        prev_match_q <= 1'b0;
      end
    end
  end

`ifdef CLKDIV_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d, high_sum_q;

  // High-time next value: the span's first cycle is always high
  always_comb begin
    hcnt_d = hcnt_q;
    if (span_start) hcnt_d = CNT_W'(1);
    else if (counting && sync2_q)
      hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 1'b1;
  end

  // High-time accumulator and its result latch
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hcnt_q     <= '0;
      high_sum_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      if (done_enter) high_sum_q <= hcnt_q;
    end
  end

  assign mif.high_sum = high_sum_q;
`else
  assign mif.high_sum = '0;
`endif

  assign mif.period_sum = period_sum_q;
  assign mif.meas_valid = meas_valid_q;
  assign mif.locked     = locked_q;
  assign mif.timeout    = timeout_q;
  assign mif.busy       = busy;
  assign mif.dbg_state  = state_q;

endmodule

// File: tb/tb_clkdiv_meter.sv
// tb_clkdiv_meter: drives a period-by-period clk_in model into two meters
// (16-bit and 4-bit accumulators) and checks every result strobe against
// sums computed from the generated period list.
module tb_clkdiv_meter;

  localparam int CW     = 16;
  localparam int SAT_W  = 4;
  localparam int N      = 2;
  localparam int EXPECT = 11;
  localparam int TOL    = 1;
  localparam int TMO    = 64;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- DUTs ----------------
  logic clkin;
  clkdiv_meter_if #(.CNT_W(CW))    m_if ();
  clkdiv_meter_if #(.CNT_W(SAT_W)) s_if ();
  assign m_if.clk_in = clkin;
  assign s_if.clk_in = clkin;

  clkdiv_meter #(.CNT_W(CW), .AVG_LOG2(1), .EXPECT(EXPECT), .TOL(TOL),
                 .TIMEOUT(TMO)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mif(m_if.slave));

  clkdiv_meter #(.CNT_W(SAT_W), .AVG_LOG2(1), .EXPECT(EXPECT), .TOL(TOL),
                 .TIMEOUT(1024)) u_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mif(s_if.slave));

  // ---------------- clk_in generator ----------------
  typedef struct { int len; int hi; } per_t;
  per_t gen_q[$];
  per_t cur;
  int   ph;

  initial begin
    clkin = 1'b0;
    ph    = 0;
    cur   = '{len: 0, hi: 0};
    forever begin
      @(posedge sys_clk);
      #2;
      if (ph == 0 && gen_q.size() > 0) begin
        cur = gen_q.pop_front();
        ph  = cur.len;
      end
      if (ph > 0) begin
        clkin = (ph > cur.len - cur.hi);
        ph--;
      end else begin
        clkin = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks, n_pass, n_fail;
  int dut_pulses, sat_pulses;
  logic [CW-1:0] exp_q[$], exp_h_q[$], sexp_q[$], sexp_h_q[$];
  logic          exp_l_q[$], sexp_l_q[$];
  logic [CW-1:0] last_p_exp, last_h_exp;
  int mdl_l[$], mdl_h[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? s_if.busy : m_if.busy;
  endfunction
  function automatic logic locked_of(input int sel);
    return (sel == 1) ? s_if.locked : m_if.locked;
  endfunction
  function automatic logic timeout_of(input int sel);
    return (sel == 1) ? s_if.timeout : m_if.timeout;
  endfunction

  // One cycle: wait for the falling edge and score any result strobe
  task automatic tick();
    @(negedge sys_clk);
    if (m_if.meas_valid === 1'b1) begin
      dut_pulses++;
      if (exp_q.size() == 0) check("dut_unexpected_pulse", 32'(m_if.meas_valid), 32'd0);
      else begin
        last_p_exp = exp_q.pop_front();
        last_h_exp = exp_h_q.pop_front();
        check("dut_period_sum", 32'(m_if.period_sum), 32'(last_p_exp));
        check("dut_high_sum", 32'(m_if.high_sum), 32'(last_h_exp));
        check("dut_locked", 32'(m_if.locked), 32'(exp_l_q.pop_front()));
      end
    end
    if (s_if.meas_valid === 1'b1) begin
      sat_pulses++;
      if (sexp_q.size() == 0) check("sat_unexpected_pulse", 32'(s_if.meas_valid), 32'd0);
      else begin
        check("sat_period_sum", 32'(s_if.period_sum), 32'(sexp_q.pop_front()));
        check("sat_high_sum", 32'(s_if.high_sum), 32'(sexp_h_q.pop_front()));
        check("sat_locked", 32'(s_if.locked), 32'(sexp_l_q.pop_front()));
      end
    end
  endtask

  task automatic add_period(input int l, input int h);
    mdl_l.push_back(l);
    mdl_h.push_back(h);
  endtask

  // Reference: each result is the saturated sum of N consecutive periods
  task automatic build_exp(input int sel, input int m_meas);
    int maxv, sp, sh, dev;
    bit prev, match, lock;
    maxv = (sel == 1) ? (1 << SAT_W) - 1 : (1 << CW) - 1;
    prev = 1'b0;
    for (int m = 0; m < m_meas; m++) begin
      sp = 0;
      sh = 0;
      for (int j = 0; j < N; j++) begin
        sp += mdl_l[m * N + j];
        sh += mdl_h[m * N + j];
      end
      if (sp > maxv) sp = maxv;
      if (sh > maxv) sh = maxv;
`ifndef CLKDIV_METER_DUTY_EN
      sh = 0;
`endif
      dev   = (sp > EXPECT) ? sp - EXPECT : EXPECT - sp;
      match = (dev <= TOL);
      lock  = prev && match;
      prev  = match;
      if (sel == 1) begin
        sexp_q.push_back(CW'(sp));
        sexp_h_q.push_back(CW'(sh));
        sexp_l_q.push_back(lock);
      end else begin
        exp_q.push_back(CW'(sp));
        exp_h_q.push_back(CW'(sh));
        exp_l_q.push_back(lock);
      end
    end
  endtask

  task automatic wait_gen_idle();
    for (int c = 0; c < 2000; c++) begin
      if (ph == 0 && gen_q.size() == 0) break;
      tick();
    end
  endtask

  // Start one meter, feed the model period list, collect m_meas results
  task automatic run(input int sel, input bit cont_mode, input int m_meas);
    int p0, pn;
    bit done;
    build_exp(sel, m_meas);
    p0 = (sel == 1) ? sat_pulses : dut_pulses;
    if (sel == 1) begin s_if.cont = cont_mode; s_if.start = 1'b1; end
    else          begin m_if.cont = cont_mode; m_if.start = 1'b1; end
    tick();
    s_if.start = 1'b0;
    m_if.start = 1'b0;
    check("busy_after_start", 32'(busy_of(sel)), 32'd1);
    check("locked_after_start", 32'(locked_of(sel)), 32'd0);
    check("timeout_after_start", 32'(timeout_of(sel)), 32'd0);
    foreach (mdl_l[i]) gen_q.push_back('{len: mdl_l[i], hi: mdl_h[i]});
    done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      pn = ((sel == 1) ? sat_pulses : dut_pulses) - p0;
      if (pn >= m_meas) begin
        m_if.cont = 1'b0;
        s_if.cont = 1'b0;
        if (busy_of(sel) == 1'b0) begin done = 1'b1; break; end
      end
    end
    pn = ((sel == 1) ? sat_pulses : dut_pulses) - p0;
    check("run_completed", 32'(done), 32'd1);
    check("pulse_count", 32'(pn), 32'(m_meas));
    check("scoreboard_drained", 32'((sel == 1) ? sexp_q.size() : exp_q.size()), 32'd0);
    wait_gen_idle();
    mdl_l.delete();
    mdl_h.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int l, h, p0;
    n_checks = 0; n_pass = 0; n_fail = 0;
    dut_pulses = 0; sat_pulses = 0;
    last_p_exp = '0; last_h_exp = '0;
    sys_rst = 1'b1;
    m_if.start = 1'b0; m_if.cont = 1'b0;
    s_if.start = 1'b0; s_if.cont = 1'b0;
    repeat (3) tick();

    check("rst_period_sum", 32'(m_if.period_sum), 32'd0);
    check("rst_high_sum", 32'(m_if.high_sum), 32'd0);
    check("rst_meas_valid", 32'(m_if.meas_valid), 32'd0);
    check("rst_locked", 32'(m_if.locked), 32'd0);
    check("rst_timeout", 32'(m_if.timeout), 32'd0);
    check("rst_busy", 32'(m_if.busy), 32'd0);
    check("rst_state", 32'(m_if.dbg_state), 32'd0);
    check("rst_sat_period_sum", 32'(s_if.period_sum), 32'd0);
    check("rst_sat_high_sum", 32'(s_if.high_sum), 32'd0);
    check("rst_sat_flags", 32'({s_if.meas_valid, s_if.locked, s_if.timeout, s_if.busy}), 32'd0);
    check("rst_sat_state", 32'(s_if.dbg_state), 32'd0);
    sys_rst = 1'b0;
    repeat (2) tick();

    // Ideal divide-by-6, single shot
    repeat (N + 1) add_period(6, 3);
    run(0, 1'b0, 1);

    // Divide-by-5.5, continuous
    for (int i = 0; i < 11; i++) add_period((i % 2) ? 6 : 5, (i % 2) ? 3 : 2);
    run(0, 1'b1, 5);

    // Divide-by-5.5 switching to divide-by-7 mid-run
    for (int i = 0; i < 5; i++) add_period((i % 2) ? 6 : 5, (i % 2) ? 3 : 2);
    for (int i = 0; i < 8; i++) add_period(7, 3);
    run(0, 1'b1, 6);

    // Random period/high-time sequences, continuous
    repeat (3) begin
      for (int i = 0; i < 4 * N + 1; i++) begin
        l = int'($urandom_range(20, 4));
        h = int'($urandom_range(l - 2, 2));
        add_period(l, h);
      end
      run(0, 1'b1, 4);
    end

    // clk_in held low: watchdog fires, sums untouched
    p0 = dut_pulses;
    m_if.cont = 1'b0;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    check("tmo_busy_armed", 32'(m_if.busy), 32'd1);
    repeat (40) tick();
    check("tmo_not_yet", 32'(m_if.timeout), 32'd0);
    repeat (60) tick();
    check("tmo_timeout", 32'(m_if.timeout), 32'd1);
    check("tmo_busy", 32'(m_if.busy), 32'd0);
    check("tmo_locked", 32'(m_if.locked), 32'd0);
    check("tmo_no_pulse", 32'(dut_pulses - p0), 32'd0);
    check("tmo_period_kept", 32'(m_if.period_sum), 32'(last_p_exp));
    check("tmo_high_kept", 32'(m_if.high_sum), 32'(last_h_exp));

    // Reset pulsed mid-measurement
    m_if.cont = 1'b1;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    repeat (6) gen_q.push_back('{len: 6, hi: 3});
    repeat (10) tick();
    check("midrst_busy_before", 32'(m_if.busy), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("midrst_period_sum", 32'(m_if.period_sum), 32'd0);
    check("midrst_high_sum", 32'(m_if.high_sum), 32'd0);
    check("midrst_flags", 32'({m_if.meas_valid, m_if.locked, m_if.timeout, m_if.busy}), 32'd0);
    check("midrst_state", 32'(m_if.dbg_state), 32'd0);
    gen_q.delete();
    tick();
    sys_rst = 1'b0;
    m_if.cont = 1'b0;
    wait_gen_idle();
    tick();
    repeat (N + 1) add_period(6, 3);
    run(0, 1'b0, 1);

    // 4-bit accumulators with divide-by-20: saturated, mismatch
    repeat (N + 1) add_period(20, 10);
    run(1, 1'b0, 1);
    check("sat_locked_end", 32'(s_if.locked), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
